// File: rtl/md_pkg.sv
// Shared op codes, FSM state type and op-decode helpers for the multiply/divide unit.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // finish flags the edge that performs the last quotient bit
  assign finish  = running && (cnt == '0);
  assign shifted = {remainder, quotient[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running   <= 1'b0;
      cnt       <= '0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (cancel) begin
      running <= 1'b0;
    end else if (start) begin
      running   <= 1'b1;
      cnt       <= CW'(WIDTH - 1);
      dsr       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (running) begin
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
import md_pkg::*;

module mul_div_unit #(
  parameter int WIDTH         = 32,
  parameter bit MUL_ITERATIVE = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  logic               accept, a_neg, b_neg;
  logic               neg_q, neg_r, div_zero, div_finish;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b, src1_q;
  logic [WIDTH-1:0]   q_mag, r_mag, q_fix, r_fix;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt, prod_mag, prod;
  logic [CW-1:0]      cnt;

  assign req_ready = (state == IDLE) && !cancel;
  assign accept    = req_valid && req_ready;

  always_comb begin
    a_neg    = is_signed(req_op) && req_src1[WIDTH-1];
    b_neg    = is_signed(req_op) && req_src2[WIDTH-1];
    in_mag_a = a_neg ? -req_src1 : req_src1;
    in_mag_b = b_neg ? -req_src2 : req_src2;
    acc_nxt  = mplier[0] ? acc + mcand : acc;
    prod_mag = MUL_ITERATIVE ? acc_nxt : mcand * {{WIDTH{1'b0}}, mplier};
    prod     = neg_q ? -prod_mag : prod_mag;
    q_fix    = neg_q ? -q_mag : q_mag;
    r_fix    = neg_r ? -r_mag : r_mag;
  end

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept && is_div(req_op)),
    .cancel    (cancel),
    .dividend  (in_mag_a),
    .divisor   (in_mag_b),
    .quotient  (q_mag),
    .remainder (r_mag),
    .finish    (div_finish)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      src1_q   <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (req_src2 == '0);
            src1_q   <= req_src1;
            mcand    <= {{WIDTH{1'b0}}, in_mag_a};
            mplier   <= in_mag_b;
            acc      <= '0;
            cnt      <= CW'(WIDTH - 1);
            if (is_mul(req_op)) begin
              state <= MUL;
              busy  <= 1'b1;
            end else if (is_div(req_op)) begin
              state <= DIV;
              busy  <= 1'b1;
            end else begin
              if (req_op == OP_MTHI) hi <= req_src1;
              if (req_op == OP_MTLO) lo <= req_src1;
              done <= 1'b1;
            end
          end
          MUL: begin
            // iterative mode folds the last partial product into the write edge
            if (!MUL_ITERATIVE || cnt == '0) begin
              hi    <= prod[2*WIDTH-1:WIDTH];
              lo    <= prod[WIDTH-1:0];
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              acc    <= acc_nxt;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt - CW'(1);
            end
          end
          DIV: if (div_finish) state <= FIX;
          FIX: begin
            if (div_zero) begin
              hi <= src1_q;
              lo <= '1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench: two instances (array and iterative multiply) driven by the same request stream.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_src1 = 32'd0;
  logic [31:0] req_src2 = 32'd0;
  logic        cancel = 1'b0;
  logic        req_ready0, busy0, done0, req_ready1, busy1, done1;
  logic [31:0] hi0, lo0, hi1, lo1;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   brun0 = 0;
  int   brun1 = 0;

  mul_div_unit #(.WIDTH(32), .MUL_ITERATIVE(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready0),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

  mul_div_unit #(.WIDTH(32), .MUL_ITERATIVE(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready1),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_done(input exp_t e, input string tag, input logic [31:0] h,
                            input logic [31:0] l, input int bcount);
    cmp32({e.name, "_hi", tag}, h, e.hi);
    cmp32({e.name, "_lo", tag}, l, e.lo);
    cmp_int({e.name, "_done_cycle", tag}, cyc, e.cyc);
    cmp_int({e.name, "_busy_cycles", tag}, bcount, e.busy);
  endtask

  // monitors: sample 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (!resetn || cancel) brun0 = 0;
    else if (done0) begin
      if (busy0) cmp32("busy_with_done0", 32'(busy0), 32'd0);
      if (q0.size() == 0) cmp_int("unexpected_done0", 1, 0);
      else check_done(q0.pop_front(), "0", hi0, lo0, brun0);
      brun0 = 0;
    end else if (busy0) brun0++;
  end

  always @(posedge clk) begin
    #2;
    if (!resetn || cancel) brun1 = 0;
    else if (done1) begin
      if (busy1) cmp32("busy_with_done1", 32'(busy1), 32'd0);
      if (q1.size() == 0) cmp_int("unexpected_done1", 1, 0);
      else check_done(q1.pop_front(), "1", hi1, lo1, brun1);
      brun1 = 0;
    end else if (busy1) brun1++;
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat0,
                       input int lat1, input bit expect_done, input bit now, input string nm);
    int   n = 0;
    exp_t e;
    if (!now) @(negedge clk);
    while (!(req_ready0 && req_ready1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(req_ready0 && req_ready1)) begin
      cmp_int({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    req_op    = 3'($urandom_range(0, 7));
    if (expect_done) begin
      e = '{nm, ehi, elo, cyc + lat0 - 1, lat0 - 1};
      q0.push_back(e);
      e = '{nm, ehi, elo, cyc + lat1 - 1, lat1 - 1};
      q1.push_back(e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cmp32("reset_hi", hi0, 32'd0);
    cmp32("reset_lo", lo0, 32'd0);
    cmp32("reset_busy", {31'd0, busy0 | busy1}, 32'd0);
    cmp32("reset_done", {31'd0, done0 | done1}, 32'd0);
    cmp32("reset_ready", {31'd0, req_ready0 & req_ready1}, 32'd1);

    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 2, 33, 1, 0, "mult_m1xm1");
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 2, 33, 1, 0, "multu_max");
    issue(3'd2, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 34, 34, 1, 0, "div_7_m2");
    issue(3'd3, 32'd7, 32'hFFFFFFFE, 32'h7, 32'h0, 34, 34, 1, 0, "divu_7_big");
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34, 34, 1, 0, "div_ovf");
    issue(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 34, 34, 1, 0, "divu_by0");
    issue(3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 34, 34, 1, 0, "div_neg_by0");
    issue(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 2, 33, 1, 0, "mult_m3x7");
    issue(3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFEB, 1, 1, 1, 0, "mthi");
    issue(3'd5, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1, 1, 1, 0, "mtlo");
    issue(3'd6, 32'hDEADBEEF, 32'd1, 32'h12345678, 32'h9ABCDEF0, 1, 1, 1, 0, "reserved6");
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34, 1, 0, "div_m7_2");

    // flush a divide in flight, then issue straight after the flush edge
    issue(3'd2, 32'd100, 32'd3, 32'h0, 32'h0, 34, 34, 0, 0, "div_cancelled");
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    #1;
    cmp32("cancel_ready", {31'd0, req_ready0 | req_ready1}, 32'd0);
    @(posedge clk);
    #1;
    cmp32("cancel_busy", {31'd0, busy0 | busy1}, 32'd0);
    cmp32("cancel_hi_kept", hi0, 32'hFFFFFFFF);
    cmp32("cancel_lo_kept", lo1, 32'hFFFFFFFD);
    @(negedge clk);
    cancel = 1'b0;
    issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 2, 33, 1, 1, "multu_after_cancel");

    // asynchronous reset in the middle of a divide
    issue(3'd2, 32'd100, 32'd3, 32'h0, 32'h0, 34, 34, 0, 0, "div_reset");
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    cmp32("rst_mid_hi", hi0 | hi1, 32'd0);
    cmp32("rst_mid_lo", lo0 | lo1, 32'd0);
    cmp32("rst_mid_busy", {31'd0, busy0 | busy1}, 32'd0);
    cmp32("rst_mid_done", {31'd0, done0 | done1}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cmp32("rst_release_ready", {31'd0, req_ready0 & req_ready1}, 32'd1);

    issue(3'd0, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h0, 2, 33, 1, 0, "mult_minx2");

    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    while (q0.size() != 0) begin
      cmp_int({q0.pop_front().name, "_no_done0"}, 0, 1);
    end
    while (q1.size() != 0) begin
      cmp_int({q1.pop_front().name, "_no_done1"}, 0, 1);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
